// File: rtl/fp16_pkg.sv
// rtl/fp16_pkg.sv - FP16 type, constants and ordering helpers shared by datapath blocks
package fp16_pkg;

  typedef logic [15:0] fp16_t;

  localparam fp16_t FP16_POS_ZERO = 16'h0000;
  localparam fp16_t FP16_NEG_ZERO = 16'h8000;
  localparam fp16_t FP16_ONE      = 16'h3C00;
  localparam fp16_t FP16_POS_INF  = 16'h7C00;
  localparam fp16_t FP16_NEG_INF  = 16'hFC00;
  localparam fp16_t FP16_QNAN     = 16'h7E00;

  function automatic logic fp16_is_nan(input fp16_t a);
    return (a[14:10] == 5'h1F) && (a[9:0] != 10'h000);
  endfunction

  // Strict a > b; NaN sits below -Inf, all NaNs equal, +0 equals -0.
  function automatic logic fp16_gt(input fp16_t a, input fp16_t b);
    logic        gt;
    logic [14:0] a_mag;
    logic [14:0] b_mag;
    a_mag = a[14:0];
    b_mag = b[14:0];
    if (fp16_is_nan(a)) begin
      gt = 1'b0;
    end else if (fp16_is_nan(b)) begin
      gt = 1'b1;
    end else if ((a_mag == 15'd0) && (b_mag == 15'd0)) begin
      gt = 1'b0;
    end else if (a[15] != b[15]) begin
      gt = b[15];
    end else if (!a[15]) begin
      gt = (a_mag > b_mag);
    end else begin
      gt = (a_mag < b_mag);
    end
    return gt;
  endfunction

endpackage

// File: rtl/fp16_max_select.sv
// rtl/fp16_max_select.sv - two-input FP16 max with index carry, left operand wins ties
module fp16_max_select
  import fp16_pkg::*;
#(
  parameter int IDX_W = 2
) (
  input  logic [15:0]      a_value,
  input  logic [IDX_W-1:0] a_index,
  input  logic [15:0]      b_value,
  input  logic [IDX_W-1:0] b_index,
  output logic [15:0]      out_value,
  output logic [IDX_W-1:0] out_index
);

  always_comb begin
    out_value = a_value;
    out_index = a_index;
    if (fp16_gt(b_value, a_value)) begin
      out_value = b_value;
      out_index = b_index;
    end
  end

endmodule

// File: rtl/one_hot_encoder.sv
// rtl/one_hot_encoder.sv - registered FP16 argmax over N scores, one-hot result with valid
module one_hot_encoder
  import fp16_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [15:0]  inputs [0:N-1],
  output logic         out_valid,
  output logic [N-1:0] outputs
);

  localparam int LEVELS = (N > 1) ? $clog2(N) : 0;
  localparam int LEAVES = 1 << LEVELS;
  localparam int IDX_W  = (N > 1) ? $clog2(N) : 1;

  // Heap-ordered tree: node k reduces children 2k+1 (left) and 2k+2 (right); root is node 0.
  fp16_t            node_value [0:2*LEAVES-2];
  logic [IDX_W-1:0] node_index [0:2*LEAVES-2];

  genvar g;
  generate
    for (g = 0; g < LEAVES; g++) begin : g_leaf
      if (g < N) begin : g_real
        assign node_value[LEAVES-1+g] = inputs[g];
      end else begin : g_pad
        // Padding sits right of every real input and ranks lowest, so it never wins.
        assign node_value[LEAVES-1+g] = FP16_QNAN;
      end
      assign node_index[LEAVES-1+g] = IDX_W'(g);
    end

    for (g = 0; g < LEAVES-1; g++) begin : g_node
      fp16_max_select #(.IDX_W(IDX_W)) u_sel (
        .a_value   (node_value[2*g+1]),
        .a_index   (node_index[2*g+1]),
        .b_value   (node_value[2*g+2]),
        .b_index   (node_index[2*g+2]),
        .out_value (node_value[g]),
        .out_index (node_index[g])
      );
    end
  endgenerate

  logic         out_valid_d, out_valid_q;
  logic [N-1:0] outputs_d, outputs_q;

  always_comb begin
    out_valid_d = in_valid;
    outputs_d   = outputs_q;
    if (in_valid) begin
      for (int i = 0; i < N; i++) begin
        outputs_d[i] = (node_index[0] == IDX_W'(i));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      outputs_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      outputs_q   <= outputs_d;
    end
  end

  assign out_valid = out_valid_q;
  assign outputs   = outputs_q;

endmodule

// File: tb/tb_one_hot_encoder.sv
// tb/tb_one_hot_encoder.sv - directed self-checking bench for one_hot_encoder at N = 4, 1 and 7
module tb_one_hot_encoder;

  logic        clk;
  logic        rst_n;

  logic        v4, v1, v7;
  logic [15:0] in4 [0:3];
  logic [15:0] in1 [0:0];
  logic [15:0] in7 [0:6];
  logic        ov4, ov1, ov7;
  logic [3:0]  o4;
  logic [0:0]  o1;
  logic [6:0]  o7;

  int n_vec;
  int n_miss;

  one_hot_encoder #(.N(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(v4), .inputs(in4), .out_valid(ov4), .outputs(o4)
  );
  one_hot_encoder #(.N(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .inputs(in1), .out_valid(ov1), .outputs(o1)
  );
  one_hot_encoder #(.N(7)) dut7 (
    .clk(clk), .rst_n(rst_n), .in_valid(v7), .inputs(in7), .out_valid(ov7), .outputs(o7)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Called at a negedge: drive one N=4 vector, then check it one edge later.
  task automatic vec4(input string tag, input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] c, input logic [15:0] d, input logic [3:0] exp);
    in4[0] = a; in4[1] = b; in4[2] = c; in4[3] = d;
    v4 = 1'b1;
    @(negedge clk);
    check({tag, "_valid"}, 8'(ov4), 8'd1);
    check(tag, 8'(o4), 8'(exp));
  endtask

  logic [3:0] last4;
  logic [6:0] last7;
  int         k7;

  initial begin
    n_vec  = 0;
    n_miss = 0;
    rst_n  = 1'b0;
    v4 = 1'b0; v1 = 1'b0; v7 = 1'b0;
    for (int i = 0; i < 4; i++) in4[i] = 16'h0000;
    in1[0] = 16'h0000;
    for (int i = 0; i < 7; i++) in7[i] = 16'h0000;

    repeat (2) @(negedge clk);
    check("reset_outputs", 8'(o4), 8'd0);
    check("reset_valid", 8'(ov4), 8'd0);
    rst_n = 1'b1;

    vec4("mixed_a", 16'h3C00, 16'h4000, 16'hBC00, 16'h3800, 4'b0010);
    vec4("mixed_b", 16'hC000, 16'h4000, 16'h3C00, 16'h3800, 4'b0010);
    vec4("mixed_c", 16'h3800, 16'h3C00, 16'h4000, 16'h4200, 4'b1000);
    vec4("mixed_d", 16'h4200, 16'h4000, 16'h3C00, 16'h3800, 4'b0001);

    // Asynchronous reset mid-cycle, away from any edge.
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_outputs", 8'(o4), 8'd0);
    check("async_reset_valid", 8'(ov4), 8'd0);
    @(posedge clk);
    #1;
    check("reset_hold_outputs", 8'(o4), 8'd0);
    check("reset_hold_valid", 8'(ov4), 8'd0);
    @(negedge clk);
    rst_n = 1'b1;

    vec4("tie_pos", 16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00, 4'b0001);
    vec4("tie_neg", 16'hBC00, 16'hBC00, 16'hBC00, 16'hBC00, 4'b0001);
    vec4("tie_pair", 16'h3800, 16'h4000, 16'h4000, 16'h3800, 4'b0010);
    vec4("tie_zero", 16'h0000, 16'h8000, 16'h0000, 16'h8000, 4'b0001);
    vec4("ulp_up", 16'h3C00, 16'h3C01, 16'h3C02, 16'h3C03, 4'b1000);
    vec4("ulp_down", 16'h3C03, 16'h3C02, 16'h3C01, 16'h3C00, 4'b0001);
    vec4("spec_nan_ninf", 16'h7E00, 16'hFC00, 16'h8001, 16'hBC00, 4'b0100);
    vec4("spec_inf", 16'h7C00, 16'h7BFF, 16'h7E00, 16'h0000, 4'b0001);
    vec4("spec_all_nan", 16'h7E00, 16'h7E00, 16'h7E00, 16'h7E00, 4'b0001);
    v4 = 1'b0;
    @(negedge clk);

    // Streaming: ten back-to-back vectors on all three widths.
    last4 = 4'b0000;
    last7 = 7'b0000000;
    for (int i = 0; i < 10; i++) begin
      for (int j = 0; j < 4; j++) in4[j] = (j % 2 == 0) ? 16'hC000 : 16'h3C00;
      in4[i % 4] = 16'h4000 + 16'(i);
      in1[0] = (i % 2 == 0) ? 16'hFC00 : 16'h7E00;
      k7 = (i * 3) % 7;
      for (int j = 0; j < 7; j++) in7[j] = 16'h3C00 + 16'(j);
      in7[k7] = 16'h4400;
      v4 = 1'b1; v1 = 1'b1; v7 = 1'b1;
      last4 = 4'(1 << (i % 4));
      last7 = 7'(1 << k7);
      @(negedge clk);
      check($sformatf("stream4_%0d_valid", i), 8'(ov4), 8'd1);
      check($sformatf("stream4_%0d", i), 8'(o4), 8'(last4));
      check($sformatf("stream1_%0d_valid", i), 8'(ov1), 8'd1);
      check($sformatf("stream1_%0d", i), 8'(o1), 8'd1);
      check($sformatf("stream7_%0d_valid", i), 8'(ov7), 8'd1);
      check($sformatf("stream7_%0d", i), 8'(o7), 8'(last7));
    end
    v4 = 1'b0; v1 = 1'b0; v7 = 1'b0;
    for (int i = 0; i < 4; i++) in4[i] = 16'h7C00;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check($sformatf("idle4_%0d_valid", i), 8'(ov4), 8'd0);
      check($sformatf("idle4_%0d_hold", i), 8'(o4), 8'(last4));
      check($sformatf("idle1_%0d_valid", i), 8'(ov1), 8'd0);
      check($sformatf("idle1_%0d_hold", i), 8'(o1), 8'd1);
      check($sformatf("idle7_%0d_valid", i), 8'(ov7), 8'd0);
      check($sformatf("idle7_%0d_hold", i), 8'(o7), 8'b01000000);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
